// File: rtl/lobster_dbus_arbiter_pkg.sv
// Shared types for the lobster data-bus arbiter.
// Requester ids, state encoding and round-robin helper.
package lobster_dbus_pkg;

    localparam int DBUS_NREQ = 3;

    localparam logic [1:0] DBUS_REQ_FETCH = 2'd0;
    localparam logic [1:0] DBUS_REQ_LOAD  = 2'd1;
    localparam logic [1:0] DBUS_REQ_STORE = 2'd2;

    typedef enum logic {
        DBUS_IDLE,
        DBUS_BUSY
    } dbus_state_e;

    function automatic logic [1:0] dbus_next_id(input logic [1:0] id);
        return (id == DBUS_REQ_STORE) ? DBUS_REQ_FETCH : id + 2'd1;
    endfunction

endpackage

// File: rtl/lobster_dbus_arbiter_if.sv
// Requester and SRAM-side signal bundle of the data-bus arbiter.
// slave = arbiter view, master = CPU/SRAM view.
interface lobster_dbus_arbiter_if #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64
);
    logic [2:0]              req_valid;
    logic [2:0]              req_ready;
    logic [2:0]              req_we;
    logic [3*ADDR_WIDTH-1:0] req_addr;
    logic [3*DATA_WIDTH-1:0] req_wdata;
    logic [2:0]              resp_valid;
    logic                    resp_err;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    mem_ce;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_rdy;
    logic                    busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_rdata, mem_rdy,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_ce, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_rdata, mem_rdy,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_ce, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/lobster_dbus_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker.
// Searches upward from ptr_i, wrapping 2 -> 0.
module lobster_rr_pick3
    import lobster_dbus_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o,
    output logic [1:0] idx_o,
    output logic       any_o
);

    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    always_comb begin
        c0 = (ptr_i == 2'd3) ? DBUS_REQ_FETCH : ptr_i;
        c1 = dbus_next_id(c0);
        c2 = dbus_next_id(c1);
        if (req_i[c0])      idx_o = c0;
        else if (req_i[c1]) idx_o = c1;
        else                idx_o = c2;
        any_o = |req_i;
        gnt_o = any_o ? (3'b001 << idx_o) : 3'b000;
    end

endmodule

// File: rtl/lobster_dbus_arbiter.sv
// Single-outstanding sequencer for the CPU's SRAM port.
// Round-robin over fetch/load/store with rdy handshake and timeout.
module lobster_dbus_arbiter
    import lobster_dbus_pkg::*;
#(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    lobster_dbus_arbiter_if.slave bus
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    dbus_state_e           state_q;
    logic [1:0]            rr_ptr_q;
    logic [1:0]            gid_q;
    logic [TW-1:0]         timer_q;
    logic                  mem_ce_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [2:0]            resp_valid_q;
    logic                  resp_err_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    logic [2:0] gnt;
    logic [1:0] gidx;
    logic       gany;

    lobster_rr_pick3 u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    assign bus.req_ready  = (state_q == DBUS_IDLE && !rst) ? gnt : 3'b000;
    assign bus.mem_ce     = mem_ce_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.busy       = (state_q == DBUS_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DBUS_IDLE;
            rr_ptr_q     <= DBUS_REQ_FETCH;
            gid_q        <= DBUS_REQ_FETCH;
            timer_q      <= '0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 3'b000;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 3'b000;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            unique case (state_q)
                DBUS_IDLE: begin
                    if (gany) begin
                        gid_q       <= gidx;
                        rr_ptr_q    <= dbus_next_id(gidx);
                        timer_q     <= '0;
                        mem_ce_q    <= 1'b1;
                        mem_we_q    <= (gidx == DBUS_REQ_FETCH) ? 1'b0
                                                                : bus.req_we[gidx];
                        mem_addr_q  <= bus.req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata_q <= bus.req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
                        state_q     <= DBUS_BUSY;
                    end
                end
                DBUS_BUSY: begin
                    timer_q <= timer_q + TW'(1);
                    // rdy takes precedence over a coincident timeout
                    if (bus.mem_rdy) begin
                        resp_valid_q <= 3'b001 << gid_q;
                        resp_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
                        mem_ce_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        state_q      <= DBUS_IDLE;
                    end else if (timer_q == TLAST) begin
                        resp_valid_q <= 3'b001 << gid_q;
                        resp_err_q   <= 1'b1;
                        mem_ce_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        state_q      <= DBUS_IDLE;
                    end
                end
                default: state_q <= DBUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lobster_dbus_arbiter.sv
// Directed bench for lobster_dbus_arbiter with TIMEOUT=4.
// Checks fetch, round-robin, store, timeout and reset boundaries.
module tb_lobster_dbus_arbiter;

    localparam int AW = 36;
    localparam int DW = 64;
    localparam int TO = 4;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    lobster_dbus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    lobster_dbus_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_we[i] = we;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    logic [2:0]    rr_rdy [4];
    logic [AW-1:0] rr_adr [4];
    logic          rr_we  [4];

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_rdy   = 1'b0;
        cyc();
        cyc();

        // reset state
        bus.req_valid = 3'b001;
        #1;
        chk("rst_ready", bus.req_ready, 3'b000);
        chk("rst_ce", bus.mem_ce, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, '0);
        chk("rst_wdata", bus.mem_wdata, '0);
        chk("rst_resp", bus.resp_valid, 3'b000);
        chk("rst_err", bus.resp_err, 1'b0);
        chk("rst_rdata", bus.resp_rdata, '0);
        chk("rst_busy", bus.busy, 1'b0);
        cyc();
        rst = 1'b0;
        bus.req_valid = 3'b000;
        cyc();

        // single fetch, rdy two cycles after ce rises
        set_req(0, 1'b1, 36'hF800, '0);
        bus.req_valid = 3'b001;
        #1;
        chk("f_ready", bus.req_ready, 3'b001);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            bus.req_valid = 3'b000;
            if (c == 3) begin
                bus.mem_rdy   = 1'b1;
                bus.mem_rdata = 64'h1122334455667788;
            end
            #1;
            chk($sformatf("f_ce%0d", c), bus.mem_ce, 1'b1);
            chk($sformatf("f_we%0d", c), bus.mem_we, 1'b0);
            chk($sformatf("f_addr%0d", c), bus.mem_addr, 36'hF800);
            chk($sformatf("f_resp%0d", c), bus.resp_valid, 3'b000);
            chk($sformatf("f_busy%0d", c), bus.busy, 1'b1);
        end
        cyc();
        bus.mem_rdy = 1'b0;
        #1;
        chk("f_resp", bus.resp_valid, 3'b001);
        chk("f_err", bus.resp_err, 1'b0);
        chk("f_rdata", bus.resp_rdata, 64'h1122334455667788);
        chk("f_ce_off", bus.mem_ce, 1'b0);
        chk("f_busy_off", bus.busy, 1'b0);

        // round-robin, all valid from reset, zero-wait SRAM
        rst = 1'b1;
        cyc();
        set_req(0, 1'b1, 36'h10, 64'h1);
        set_req(1, 1'b1, 36'h20, 64'h2);
        set_req(2, 1'b1, 36'h30, 64'h3);
        bus.req_valid = 3'b111;
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'h77;
        cyc();
        rst = 1'b0;
        rr_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_adr = '{36'h10, 36'h20, 36'h30, 36'h10};
        rr_we  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_ready%0d", k), bus.req_ready, rr_rdy[k]);
            chk($sformatf("rr_gap%0d", k), bus.mem_ce, 1'b0);
            if (k > 0)
                chk($sformatf("rr_resp%0d", k), bus.resp_valid, rr_rdy[k-1]);
            cyc();
            if (k == 3) bus.req_valid = 3'b000;
            #1;
            chk($sformatf("rr_ce%0d", k), bus.mem_ce, 1'b1);
            chk($sformatf("rr_addr%0d", k), bus.mem_addr, rr_adr[k]);
            chk($sformatf("rr_we%0d", k), bus.mem_we, rr_we[k]);
            chk($sformatf("rr_noready%0d", k), bus.req_ready, 3'b000);
            cyc();
        end
        bus.mem_rdy = 1'b0;
        #1;
        chk("rr_resp_last", bus.resp_valid, 3'b001);
        chk("rr_ce_last", bus.mem_ce, 1'b0);

        // store to id 2 (rr_ptr=1)
        set_req(2, 1'b1, 36'h100, 64'hDEAD);
        bus.req_valid = 3'b100;
        #1;
        chk("s_ready", bus.req_ready, 3'b100);
        cyc();
        bus.req_valid = 3'b000;
        #1;
        chk("s_ce", bus.mem_ce, 1'b1);
        chk("s_we", bus.mem_we, 1'b1);
        chk("s_addr", bus.mem_addr, 36'h100);
        chk("s_wdata", bus.mem_wdata, 64'hDEAD);
        cyc();
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'hFFFF;
        #1;
        chk("s_we2", bus.mem_we, 1'b1);
        chk("s_wdata2", bus.mem_wdata, 64'hDEAD);
        cyc();
        bus.mem_rdy = 1'b0;
        #1;
        chk("s_resp", bus.resp_valid, 3'b100);
        chk("s_err", bus.resp_err, 1'b0);
        chk("s_rdata", bus.resp_rdata, '0);
        chk("s_we_off", bus.mem_we, 1'b0);

        // timeout on load (rr_ptr=0)
        set_req(1, 1'b0, 36'h200, '0);
        bus.req_valid = 3'b010;
        #1;
        chk("t_ready", bus.req_ready, 3'b010);
        for (int c = 1; c <= TO; c++) begin
            cyc();
            bus.req_valid = 3'b000;
            #1;
            chk($sformatf("t_ce%0d", c), bus.mem_ce, 1'b1);
            chk($sformatf("t_resp%0d", c), bus.resp_valid, 3'b000);
        end
        cyc();
        set_req(0, 1'b0, 36'h300, '0);
        bus.req_valid = 3'b001;
        #1;
        chk("t_resp", bus.resp_valid, 3'b010);
        chk("t_err", bus.resp_err, 1'b1);
        chk("t_rdata", bus.resp_rdata, '0);
        chk("t_ce_off", bus.mem_ce, 1'b0);
        chk("t_next_ready", bus.req_ready, 3'b001);
        cyc();
        bus.req_valid = 3'b000;
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'h55;
        #1;
        chk("t_next_ce", bus.mem_ce, 1'b1);
        chk("t_next_addr", bus.mem_addr, 36'h300);
        cyc();
        bus.mem_rdy = 1'b0;
        #1;
        chk("t_next_resp", bus.resp_valid, 3'b001);
        chk("t_next_err", bus.resp_err, 1'b0);
        chk("t_next_rdata", bus.resp_rdata, 64'h55);

        // rdy coincident with last timer value (rr_ptr=1)
        set_req(1, 1'b0, 36'h400, '0);
        bus.req_valid = 3'b010;
        #1;
        chk("b_ready", bus.req_ready, 3'b010);
        for (int c = 1; c <= TO; c++) begin
            cyc();
            bus.req_valid = 3'b000;
            if (c == TO) begin
                bus.mem_rdy   = 1'b1;
                bus.mem_rdata = 64'hABCD;
            end
            #1;
            chk($sformatf("b_ce%0d", c), bus.mem_ce, 1'b1);
        end
        cyc();
        bus.mem_rdy = 1'b0;
        #1;
        chk("b_resp", bus.resp_valid, 3'b010);
        chk("b_err", bus.resp_err, 1'b0);
        chk("b_rdata", bus.resp_rdata, 64'hABCD);

        // rdy pulse in IDLE is ignored
        bus.mem_rdy = 1'b1;
        cyc();
        bus.mem_rdy = 1'b0;
        #1;
        chk("i_resp", bus.resp_valid, 3'b000);
        chk("i_ce", bus.mem_ce, 1'b0);
        chk("i_busy", bus.busy, 1'b0);

        // reset in second BUSY cycle (rr_ptr=2)
        set_req(0, 1'b0, 36'h500, '0);
        bus.req_valid = 3'b001;
        #1;
        chk("r_ready", bus.req_ready, 3'b001);
        cyc();
        bus.req_valid = 3'b000;
        #1;
        chk("r_ce1", bus.mem_ce, 1'b1);
        cyc();
        rst = 1'b1;
        bus.req_valid = 3'b111;
        #1;
        chk("r_ce2", bus.mem_ce, 1'b1);
        chk("r_ready_rst", bus.req_ready, 3'b000);
        cyc();
        #1;
        chk("r_ce_off", bus.mem_ce, 1'b0);
        chk("r_we_off", bus.mem_we, 1'b0);
        chk("r_addr", bus.mem_addr, '0);
        chk("r_wdata", bus.mem_wdata, '0);
        chk("r_busy", bus.busy, 1'b0);
        chk("r_resp", bus.resp_valid, 3'b000);
        chk("r_ready_hold", bus.req_ready, 3'b000);
        cyc();
        rst = 1'b0;
        #1;
        chk("r_resp_after", bus.resp_valid, 3'b000);
        chk("r_ptr0", bus.req_ready, 3'b001);
        cyc();
        bus.req_valid = 3'b000;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lobster_dbus_arbiter.md
Name: lobster_dbus_arbiter

Overview:
Single-master sequencer for the CPU's one SRAM port (ce/we/rdy/addr/data).
It arbitrates among three requesters: instruction fetch (id 0), load (id 1) and store (id 2).
It holds one transaction outstanding at a time, enforces the ce/rdy handshake and a timeout, and returns read data or an error to the granted requester.
It sits between the execution engine's fetch/load/store logic and the memory pins of lobster_CPU.

Parameters:
ADDR_WIDTH, 36, memory address width
DATA_WIDTH, 64, memory data width
TIMEOUT, 255, max cycles in BUSY waiting for mem_rdy before aborting (≥1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  3  request per requester (bit0 fetch, bit1 load, bit2 store)
req_ready  out  3  one-hot accept; combinational, only in IDLE
req_we  in  3  per-requester write flag (fetch bit ignored, treated 0)
req_addr  in  3*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  3*DATA_WIDTH  packed write data, same packing
resp_valid  out  3  one-cycle one-hot completion pulse
resp_err  out  1  valid with resp_valid; 1 = timeout
resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid
mem_ce  out  1  command enable to SRAM
mem_we  out  1  write enable to SRAM
mem_addr  out  ADDR_WIDTH  SRAM address
mem_wdata  out  DATA_WIDTH  SRAM write data
mem_rdata  in  DATA_WIDTH  SRAM read data
mem_rdy  in  1  SRAM completion strobe
busy  out  1  high while in BUSY

Behaviour:
- Reset: state IDLE, rr_ptr=0, timer=0. mem_ce, mem_we, mem_addr, mem_wdata, resp_valid, resp_err, resp_rdata and busy all 0. req_ready is 0 while rst is high.
- Reset mid-BUSY: transaction abandoned with no resp_valid, and mem_ce=0 on the next cycle.
- States: IDLE, BUSY.
- IDLE arbitration:
  - Round-robin over req_valid, starting at rr_ptr and searching upward mod 3.
  - The winner g gets req_ready[g]=1 in the same cycle; there is no grant if req_valid=0.
  - At the clock edge: latch addr/wdata/we of g (we forced 0 for g=0), set rr_ptr = (g+1) mod 3 (2 wraps to 0), timer=0, go to BUSY.
- BUSY:
  - mem_ce=1, mem_we=latched we; mem_addr and mem_wdata are held stable for the entire state.
  - timer increments each cycle.
  - mem_rdy=1: next cycle resp_valid[g]=1, resp_err=0, resp_rdata=mem_rdata (write: resp_rdata=0). mem_ce and mem_we return to 0, state returns to IDLE.
  - mem_rdy=0 with timer==TIMEOUT-1: next cycle resp_valid[g]=1, resp_err=1, resp_rdata=0, state IDLE.
  - mem_rdy and timeout in the same cycle: rdy wins.
- Latency: accepted at edge N means mem_ce=1 from cycle N+1. mem_rdy seen in cycle M means resp in cycle M+1. The earliest next grant is in cycle M+1, so mem_ce is low for at least one cycle between transactions. With zero-wait SRAM, that is one transaction per 2 cycles.
- mem_rdy in IDLE is ignored.
- resp_valid is one cycle only and is never asserted for two requesters at once.
- A requester may drop req_valid after its accept without effect; requests are not queued.

Decomposition:
- Shared package lobster_dbus_pkg:
  - requester ids DBUS_REQ_FETCH=0, DBUS_REQ_LOAD=1, DBUS_REQ_STORE=2
  - DBUS_NREQ=3
  - state typedef {DBUS_IDLE, DBUS_BUSY}
- Sub-module lobster_rr_pick3: combinational 3-way round-robin picker (req[2:0], ptr[1:0] → one-hot grant, index, any).

Test Plan:
- Single fetch: req_valid=001, addr=0xF800, mem_rdy asserted 2 cycles after mem_ce rises, mem_rdata=0x1122334455667788 → req_ready=001 in cycle 0; mem_ce=1, mem_we=0, mem_addr=0xF800 in cycles 1–3; resp_valid=001 with that data in cycle 4.
- Round-robin, all three held valid from reset with zero-wait SRAM → grant order fetch, load, store, fetch. mem_ce low for exactly 1 cycle between transactions.
- Store: id 2, addr=0x100, wdata=0xDEAD → mem_we=1, mem_wdata=0xDEAD held until rdy; resp_valid=100, resp_err=0, resp_rdata=0.
- Timeout: TIMEOUT=4, mem_rdy never asserted → mem_ce high for 4 cycles, then resp_valid[g]=1, resp_err=1. A next request is accepted normally.
- Boundaries: mem_rdy on the same cycle as timer==TIMEOUT-1 → resp_err=0. mem_rdy pulsed in IDLE → no response. rst asserted in the second BUSY cycle → no resp_valid, all outputs 0, rr_ptr=0.
